// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared ALU/MDU operation codes and multiply/divide FSM states.
// Optional feature macro (used by importers): ALU_MDU_DIV_EN builds the divider.
package alu_mdu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_NOR   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_SLL   = 5'd10,
    OP_SRL   = 5'd11,
    OP_SRA   = 5'd12,
    OP_LUI   = 5'd13,
    OP_MFHI  = 5'd14,
    OP_MFLO  = 5'd15,
    OP_MTHI  = 5'd16,
    OP_MTLO  = 5'd17,
    OP_MULT  = 5'd18,
    OP_MULTU = 5'd19,
    OP_DIV   = 5'd20,
    OP_DIVU  = 5'd21
  } aluop_def_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/alu_mdu_mdu_iter.sv
// mdu_iter: iterative multiply (shift-add) and, with ALU_MDU_DIV_EN defined,
// restoring divide on operand magnitudes; sign correction in the FIX state.
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
`ifdef ALU_MDU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int SHW = $clog2(WIDTH);

  mdu_state_e         state_r;
  logic [SHW-1:0]     cnt_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   mag_b_r;
  logic               neg_q_r;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_bin_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]   lo_nxt_s;
  logic [2*WIDTH-1:0] prod_neg_s;
`ifdef ALU_MDU_DIV_EN
  logic               div_r;
  logic               neg_rem_r;
  logic               bzero_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     trial_s;
`endif

  assign mag_a_s    = (is_signed && a[WIDTH-1]) ? (-a) : a;
  assign mag_bin_s  = (is_signed && b[WIDTH-1]) ? (-b) : b;
  assign add_s      = {1'b0, acc_r} + (lo_r[0] ? {1'b0, mag_b_r} : {(WIDTH+1){1'b0}});
  assign prod_neg_s = -{acc_r, lo_r};
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_FIX);
`ifdef ALU_MDU_DIV_EN
  assign shl_s   = {acc_r, lo_r[WIDTH-1]};
  assign trial_s = shl_s - {1'b0, mag_b_r};
`endif

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    acc_nxt_s = add_s[WIDTH:1];
    lo_nxt_s  = {add_s[0], lo_r[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
    if (div_r) begin
      if (!trial_s[WIDTH]) begin
        acc_nxt_s = trial_s[WIDTH-1:0];
        lo_nxt_s  = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s = shl_s[WIDTH-1:0];
        lo_nxt_s  = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = add_s[WIDTH:1];
      lo_nxt_s  = {add_s[0], lo_r[WIDTH-1:1]};
    end
`endif
  end

  // Sign correction of the finished magnitude result into HI/LO values.
  always_comb begin
    hi_res = acc_r;
    lo_res = lo_r;
    if (neg_q_r) begin
      {hi_res, lo_res} = prod_neg_s;
    end else begin
      {hi_res, lo_res} = {acc_r, lo_r};
    end
`ifdef ALU_MDU_DIV_EN
    if (div_r) begin
      if (bzero_r) begin
        lo_res = {WIDTH{1'b1}};
        hi_res = a_r;
      end else begin
        lo_res = neg_q_r   ? (-lo_r)  : lo_r;
        hi_res = neg_rem_r ? (-acc_r) : acc_r;
      end
    end else begin
      lo_res = lo_res;
    end
`endif
  end

  // Iteration FSM with magnitude, counter and sign registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {SHW{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      mag_b_r   <= {WIDTH{1'b0}};
      neg_q_r   <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      div_r     <= 1'b0;
      neg_rem_r <= 1'b0;
      bzero_r   <= 1'b0;
      a_r       <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_ITER;
            cnt_r     <= {SHW{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            lo_r      <= mag_a_s;
            mag_b_r   <= mag_bin_s;
            neg_q_r   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
            div_r     <= is_div;
            neg_rem_r <= is_signed & a[WIDTH-1];
            bzero_r   <= (b == {WIDTH{1'b0}});
            a_r       <= a;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ITER: begin
          acc_r <= acc_nxt_s;
          lo_r  <= lo_nxt_s;
          if (cnt_r == SHW'(WIDTH-1)) begin
            cnt_r   <= {SHW{1'b0}};
            state_r <= ST_FIX;
          end else begin
            cnt_r <= cnt_r + SHW'(1);
          end
        end
        ST_FIX:  state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: WIDTH-bit integer unit with single-cycle ALU ops, HI/LO registers and
// an iterative multiply/divide engine behind one valid/ready request port.
// Optional feature macro: ALU_MDU_DIV_EN (restoring divider; otherwise DIV/DIVU are illegal).
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic             overflow,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  logic             accept_s, mdu_busy_s, mdu_done_s;
  logic             mdu_start_s, mdu_signed_s;
  logic             alu_ovf_s, alu_ill_s, hi_wr_s, lo_wr_s;
  logic [WIDTH-1:0] add_s, sub_s, alu_res_s, mdu_hi_s, mdu_lo_s;
  logic [SHW-1:0]   shamt_s;
  logic             out_valid_r, equal_r, overflow_r, illegal_r, eq_pend_r;
  logic [WIDTH-1:0] result_r, hi_r, lo_r;
`ifdef ALU_MDU_DIV_EN
  logic             mdu_div_s;
`endif

  assign in_ready  = ~mdu_busy_s;
  assign accept_s  = in_valid & ~mdu_busy_s;
  assign add_s     = src_a + src_b;
  assign sub_s     = src_a - src_b;
  assign shamt_s   = src_b[SHW-1:0];
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign equal     = equal_r;
  assign overflow  = overflow_r;
  assign illegal   = illegal_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

  // Single-cycle ALU decode and selection of multi-cycle starts.
  always_comb begin
    alu_res_s    = {WIDTH{1'b0}};
    alu_ovf_s    = 1'b0;
    alu_ill_s    = 1'b0;
    hi_wr_s      = 1'b0;
    lo_wr_s      = 1'b0;
    mdu_start_s  = 1'b0;
    mdu_signed_s = 1'b0;
`ifdef ALU_MDU_DIV_EN
    mdu_div_s    = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        alu_res_s = add_s;
        alu_ovf_s = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_s[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_ADDU: alu_res_s = add_s;
      OP_SUB: begin
        alu_res_s = sub_s;
        alu_ovf_s = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_s[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUBU: alu_res_s = sub_s;
      OP_AND:  alu_res_s = src_a & src_b;
      OP_OR:   alu_res_s = src_a | src_b;
      OP_XOR:  alu_res_s = src_a ^ src_b;
      OP_NOR:  alu_res_s = ~(src_a | src_b);
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_SLL:  alu_res_s = src_a << shamt_s;
      OP_SRL:  alu_res_s = src_a >> shamt_s;
      OP_SRA:  alu_res_s = WIDTH'($signed(src_a) >>> shamt_s);
      OP_LUI:  alu_res_s = {src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: alu_res_s = hi_r;
      OP_MFLO: alu_res_s = lo_r;
      OP_MTHI: begin
        alu_res_s = src_a;
        hi_wr_s   = 1'b1;
      end
      OP_MTLO: begin
        alu_res_s = src_a;
        lo_wr_s   = 1'b1;
      end
      OP_MULT: begin
        mdu_start_s  = 1'b1;
        mdu_signed_s = 1'b1;
      end
      OP_MULTU: mdu_start_s = 1'b1;
`ifdef ALU_MDU_DIV_EN
      OP_DIV: begin
        mdu_start_s  = 1'b1;
        mdu_signed_s = 1'b1;
        mdu_div_s    = 1'b1;
      end
      OP_DIVU: begin
        mdu_start_s = 1'b1;
        mdu_div_s   = 1'b1;
      end
`endif
      default: alu_ill_s = 1'b1;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept_s & mdu_start_s),
    .is_signed (mdu_signed_s),
`ifdef ALU_MDU_DIV_EN
    .is_div    (mdu_div_s),
`endif
    .a         (src_a),
    .b         (src_b),
    .busy      (mdu_busy_s),
    .done      (mdu_done_s),
    .hi_res    (mdu_hi_s),
    .lo_res    (mdu_lo_s)
  );

  // Result/flag/HI/LO registers: single-cycle results at accept, MDU results at FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      equal_r     <= 1'b0;
      overflow_r  <= 1'b0;
      illegal_r   <= 1'b0;
      eq_pend_r   <= 1'b0;
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
    end else if (accept_s && !mdu_start_s) begin
      out_valid_r <= 1'b1;
      result_r    <= alu_res_s;
      equal_r     <= (src_a == src_b);
      overflow_r  <= alu_ovf_s;
      illegal_r   <= alu_ill_s;
      if (hi_wr_s) hi_r <= src_a;
      if (lo_wr_s) lo_r <= src_a;
    end else if (accept_s) begin
      out_valid_r <= 1'b0;
      eq_pend_r   <= (src_a == src_b);
    end else if (mdu_done_s) begin
      out_valid_r <= 1'b1;
      result_r    <= mdu_lo_s;
      equal_r     <= eq_pend_r;
      overflow_r  <= 1'b0;
      illegal_r   <= 1'b0;
      hi_r        <= mdu_hi_s;
      lo_r        <= mdu_lo_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed and randomized requests checked against a behavioural
// reference model of the unit (plain 64-bit arithmetic, tracked HI/LO).
module tb_alu_mdu;

  logic        clk, rst_n, in_valid, in_ready, out_valid, equal, overflow, illegal;
  logic [4:0]  op;
  logic [31:0] src_a, src_b, result, hi, lo;
  logic [31:0] exp_hi, exp_lo;
  int          checks, errors;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .result(result),
    .equal(equal), .overflow(overflow), .illegal(illegal), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp_v);
    end
  endtask

  function automatic bit is_mdu(input logic [4:0] o);
`ifdef ALU_MDU_DIV_EN
    return (o == 5'd18) || (o == 5'd19) || (o == 5'd20) || (o == 5'd21);
`else
    return (o == 5'd18) || (o == 5'd19);
`endif
  endfunction

  // Reference model: expected result/flags, updates the modelled HI/LO.
  task automatic ref_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic ov, output logic il);
    longint sa, sb, s, q, rm;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; ov = 1'b0; il = 1'b0;
    case (o)
      5'd0:  begin s = sa + sb; r = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd1:  r = a + b;
      5'd2:  begin s = sa - sb; r = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd3:  r = a - b;
      5'd4:  r = a & b;
      5'd5:  r = a | b;
      5'd6:  r = a ^ b;
      5'd7:  r = ~(a | b);
      5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: r = a << b[4:0];
      5'd11: r = a >> b[4:0];
      5'd12: r = $signed(a) >>> b[4:0];
      5'd13: r = {b[15:0], 16'h0000};
      5'd14: r = exp_hi;
      5'd15: r = exp_lo;
      5'd16: begin r = a; exp_hi = a; end
      5'd17: begin r = a; exp_lo = a; end
      5'd18: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; r = p[31:0]; end
      5'd19: begin p = {32'h0, a} * {32'h0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; r = p[31:0]; end
`ifdef ALU_MDU_DIV_EN
      5'd20: begin
        if (b == 32'd0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = a; end
        else begin
          q = sa / sb; rm = sa % sb;
          p = q; exp_lo = p[31:0];
          p = rm; exp_hi = p[31:0];
        end
        r = exp_lo;
      end
      5'd21: begin
        if (b == 32'd0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = a; end
        else begin exp_lo = a / b; exp_hi = a % b; end
        r = exp_lo;
      end
`endif
      default: il = 1'b1;
    endcase
  endtask

  // One request: accept, measure latency, compare everything, check single pulse.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic eo, ei;
    int lat, w;
    bit mdu, got;
    mdu = is_mdu(o);
    ref_op(o, a, b, er, eo, ei);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    chk("ready_before", in_ready, 1'b1);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // while busy keep a conflicting MTHI request on the port; it must be ignored
    in_valid = mdu; op = 5'd16; src_a = $urandom; src_b = $urandom;
    lat = 0; got = 0;
    while (!got && lat < (mdu ? 100 : 3)) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1;
      else if (mdu) chk("busy_ready", in_ready, 1'b0);
      if (lat >= 32) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk($sformatf("latency_op%0d", o), lat, mdu ? 34 : 1);
    if (got) begin
      chk($sformatf("result_op%0d", o), result, er);
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
      chk("equal", equal, a == b);
      chk("overflow", overflow, eo);
      chk("illegal", illegal, ei);
      chk("ready_done", in_ready, 1'b1);
    end
    @(negedge clk);
    chk("single_pulse", out_valid, 1'b0);
  endtask

  logic [31:0] edges [5];
  logic [31:0] ra, rb;
  logic [31:0] e1, e2, e3;
  logic        xo, xi;
  int          vcount;

  initial begin
    checks = 0; errors = 0;
    edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000; edges[4] = 32'h7FFF_FFFF;
    rst_n = 1'b0; in_valid = 1'b0; op = 5'd0; src_a = 32'd0; src_b = 32'd0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {equal, overflow, illegal}, 3'b000);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Directed boundary cases
    run_op(5'd0, 32'h7FFF_FFFF, 32'h1);
    chk("add_ovf_const", {overflow, result}, {1'b1, 32'h8000_0000});
    run_op(5'd1, 32'h7FFF_FFFF, 32'h1);
    chk("addu_ovf_const", overflow, 1'b0);
    run_op(5'd2, 32'h8000_0000, 32'h1);
    run_op(5'd12, 32'h8000_0000, 32'd4);
    chk("sra_const", result, 32'hF800_0000);
    run_op(5'd18, 32'hFFFF_FFFD, 32'd7);
    chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(5'd14, 32'd0, 32'd0);
    run_op(5'd19, 32'hFFFF_FFFF, 32'd2);
    chk("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(5'd15, 32'd0, 32'd0);
`ifdef ALU_MDU_DIV_EN
    run_op(5'd20, 32'hFFFF_FFF9, 32'd2);
    chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(5'd21, 32'h1234_5678, 32'd0);
    chk("divu_zero_const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(5'd20, 32'h7, 32'd0);
`else
    run_op(5'd20, 32'd10, 32'd3);
    chk("div_off_const", {illegal, result}, {1'b1, 32'd0});
    run_op(5'd21, 32'd10, 32'd0);
`endif
    run_op(5'd31, 32'd5, 32'd5);
    chk("op31_const", illegal, 1'b1);

    // Back-to-back: SRA, SLT(-1,1), SLTU(0xFFFFFFFF,1) in consecutive cycles
    ref_op(5'd12, 32'h8000_0000, 32'd4, e1, xo, xi);
    ref_op(5'd8, 32'hFFFF_FFFF, 32'd1, e2, xo, xi);
    ref_op(5'd9, 32'hFFFF_FFFF, 32'd1, e3, xo, xi);
    chk("b2b_ref_slt", {e2[0], e3[0]}, 2'b10);
    @(negedge clk);
    op = 5'd12; src_a = 32'h8000_0000; src_b = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_v1", out_valid, 1'b1); chk("b2b_r1", result, e1);
    op = 5'd8; src_a = 32'hFFFF_FFFF; src_b = 32'd1;
    @(negedge clk);
    chk("b2b_v2", out_valid, 1'b1); chk("b2b_r2", result, e2);
    op = 5'd9;
    @(negedge clk);
    chk("b2b_v3", out_valid, 1'b1); chk("b2b_r3", result, e3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end", out_valid, 1'b0);

    // Randomized requests over all op codes and edge-biased operands
    for (int i = 0; i < 80; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 9) == 0) rb = ra;
      run_op(5'($urandom_range(0, 31)), ra, rb);
    end

    // Reset mid-multiply: abort, no HI/LO write, clean restart
    run_op(5'd16, 32'hA5A5_A5A5, 32'd0);
    @(negedge clk);
    op = 5'd18; src_a = 32'd1234; src_b = 32'd5678; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", in_ready, 1'b1);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_result", result, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("abort_no_valid", vcount, 0);
    chk("abort_hilo_kept", {hi, lo}, 64'd0);
    run_op(5'd0, 32'd100, 32'd23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
